// File: rtl/ff_bank_pkg.sv
// Shared types and helpers for the emulated TTL flip-flop bank.
//   ff_mode_t : flip-flop personality common to every channel
//   ff_edge_t : active edge of the emulated clock line
//   ff_next() : next Q given the captured data inputs and the held Q
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR,
        MODE_JK,
        MODE_D,
        MODE_T
    } ff_mode_t;

    typedef enum logic {
        EDGE_FALL,
        EDGE_RISE
    } ff_edge_t;

    localparam int unsigned N_MAX      = 32;
    localparam int unsigned FILTER_MAX = 255;
    localparam int unsigned CNT_W      = 8;

    // SR treats S=R=1 as hold; JK toggles on J=K=1; B is ignored for D and T.
    function automatic logic ff_next(ff_mode_t mode, logic a, logic b, logic q);
        logic nxt;
        nxt = q;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    default: nxt = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_D:  nxt = a;
            MODE_T:  nxt = a ? ~q : q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/clocked_ff_chan.sv
// One emulated flip-flop channel: samples the slow clock line, detects and
// optionally filters its active edge, and drives Q through the override mux.
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   clk_in_i   emulated clock line
//   pre_n_i    preset, active low, combinational
//   clr_n_i    clear, active low, combinational
//   a_i / b_i  data inputs (S/R, J/K, D, T)
//   q_o        flip-flop output (combinational from the current inputs)
module clocked_ff_chan
    import ff_bank_pkg::*;
#(
    parameter ff_mode_t    MODE   = MODE_SR,
    parameter ff_edge_t    EDGE   = EDGE_FALL,
    parameter int unsigned FILTER = 0,
    parameter logic        INIT   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_in_i,
    input  logic pre_n_i,
    input  logic clr_n_i,
    input  logic a_i,
    input  logic b_i,
    output logic q_o
);

    localparam logic              ACT    = (EDGE == EDGE_RISE);
    localparam int unsigned       CNTX_W = CNT_W + 1;
    localparam logic [CNTX_W-1:0] FILT_X = CNTX_W'(FILTER);

    logic             prev_q_q, prev_q_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             clk_q, clk_d;
    logic             cap_a_q, cap_a_d;
    logic             cap_b_q, cap_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    logic              override;
    logic              clk_act;
    logic              raw_edge;
    logic [CNTX_W-1:0] cnt_inc;
    logic              accept;
    logic              data_a;
    logic              data_b;
    logic              q_c;

    assign override = ~pre_n_i | ~clr_n_i;
    assign clk_act  = (clk_in_i == ACT);
    assign raw_edge = clk_act & (clk_q != ACT);
    assign cnt_inc  = CNTX_W'(cnt_q) + CNTX_W'(1);

    // Edge detection / glitch filter and Q selection.
    always_comb begin
        a_d      = a_i;
        b_d      = b_i;
        clk_d    = clk_in_i;
        cap_a_d  = cap_a_q;
        cap_b_d  = cap_b_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        accept   = 1'b0;
        data_a   = a_q;
        data_b   = b_q;

        // A one-sample filter accepts on the first active sample, same as no filter.
        if (FILTER <= 1) begin
            accept = raw_edge;
        end else if (pend_q) begin
            data_a = cap_a_q;
            data_b = cap_b_q;
            if (clk_act) begin
                if (cnt_inc == FILT_X) begin
                    accept = 1'b1;
                    pend_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_inc);
                end
            end else begin
                // Line dropped back before the filter expired: glitch.
                pend_d = 1'b0;
                cnt_d  = '0;
            end
        end else if (raw_edge) begin
            pend_d  = 1'b1;
            cnt_d   = CNT_W'(1);
            cap_a_d = a_q;
            cap_b_d = b_q;
        end

        // Preset/clear park the edge detector at the inactive level.
        if (override) begin
            clk_d  = ~ACT;
            pend_d = 1'b0;
            cnt_d  = '0;
        end

        if (rst_i) begin
            q_c = INIT;
        end else if (!pre_n_i) begin
            q_c = 1'b1;
        end else if (!clr_n_i) begin
            q_c = 1'b0;
        end else if (accept) begin
            q_c = ff_next(MODE, data_a, data_b, prev_q_q);
        end else begin
            q_c = prev_q_q;
        end

        prev_q_d = q_c;
    end

    // Channel state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q_q <= INIT;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            clk_q    <= ~ACT;
            cap_a_q  <= 1'b0;
            cap_b_q  <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            prev_q_q <= prev_q_d;
            a_q      <= a_d;
            b_q      <= b_d;
            clk_q    <= clk_d;
            cap_a_q  <= cap_a_d;
            cap_b_q  <= cap_b_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    assign q_o = q_c;

endmodule

// File: rtl/clocked_ff_bank.sv
// Bank of N independent emulated TTL flip-flops clocked from CLK_DRV.
//   CLK_DRV      system clock
//   RESET        synchronous active-high reset
//   CLK_IN[N]    per-channel emulated clock line
//   PRE_N[N]     per-channel preset, active low
//   CLR_N[N]     per-channel clear, active low
//   A[N], B[N]   per-channel data (S/R, J/K, D, T)
//   Q[N], Q_N[N] flip-flop outputs, Q_N always ~Q
module clocked_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int unsigned    N      = 1,
    parameter ff_mode_t       MODE   = MODE_SR,
    parameter ff_edge_t       EDGE   = EDGE_FALL,
    parameter int unsigned    FILTER = 0,
    parameter logic [N-1:0]   INIT   = '0
) (
    input  logic         CLK_DRV,
    input  logic         RESET,
    input  logic [N-1:0] CLK_IN,
    input  logic [N-1:0] PRE_N,
    input  logic [N-1:0] CLR_N,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] Q_N
);

    if (N == 0 || N > N_MAX) begin : g_bad_n
        $error("clocked_ff_bank: N must be 1..32");
    end

    if (FILTER > FILTER_MAX) begin : g_bad_filter
        $error("clocked_ff_bank: FILTER must be 0..255");
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        clocked_ff_chan #(
            .MODE   (MODE),
            .EDGE   (EDGE),
            .FILTER (FILTER),
            .INIT   (INIT[i])
        ) u_chan (
            .clk_i    (CLK_DRV),
            .rst_i    (RESET),
            .clk_in_i (CLK_IN[i]),
            .pre_n_i  (PRE_N[i]),
            .clr_n_i  (CLR_N[i]),
            .a_i      (A[i]),
            .b_i      (B[i]),
            .q_o      (Q[i])
        );
    end

    assign Q_N = ~Q;

endmodule

// File: tb/tb_clocked_ff_bank.sv
// Self-checking bench: four bank configurations (SR, JK, filtered D on the
// rising edge, filtered T with non-zero INIT) driven by directed sequences and
// random stimulus, compared every cycle against a history-window model.
module tb_clocked_ff_bank;
    import ff_bank_pkg::*;

    localparam int MAXC = 2048;
    localparam int NINST = 4;
    localparam int FE    [NINST] = '{1, 1, 3, 2};   // effective filter length
    localparam int NB    [NINST] = '{1, 4, 2, 8};   // channel count
    localparam int MD    [NINST] = '{0, 1, 2, 3};   // 0 SR, 1 JK, 2 D, 3 T
    localparam bit ACTL  [NINST] = '{0, 0, 1, 0};   // active clock level
    localparam logic [7:0] INITV [NINST] = '{8'h00, 8'h00, 8'h00, 8'hA5};

    logic clk;
    logic rst;
    logic [7:0] ck [NINST];
    logic [7:0] pn [NINST];
    logic [7:0] cn [NINST];
    logic [7:0] av [NINST];
    logic [7:0] bv [NINST];

    logic       st_rst;
    logic [7:0] st_ck [NINST];
    logic [7:0] st_pn [NINST];
    logic [7:0] st_cn [NINST];
    logic [7:0] st_av [NINST];
    logic [7:0] st_bv [NINST];

    logic [0:0] q0, qn0;
    logic [3:0] q1, qn1;
    logic [1:0] q2, qn2;
    logic [7:0] q3, qn3;

    bit         rst_h [MAXC];
    logic [7:0] ck_h  [NINST][MAXC];
    logic [7:0] pn_h  [NINST][MAXC];
    logic [7:0] cn_h  [NINST][MAXC];
    logic [7:0] av_h  [NINST][MAXC];
    logic [7:0] bv_h  [NINST][MAXC];
    logic [7:0] exp_h [NINST][MAXC];

    int t = 0;
    int n_checks = 0;
    int n_errors = 0;

    clocked_ff_bank #(.N(1), .MODE(MODE_SR), .EDGE(EDGE_FALL), .FILTER(0), .INIT(1'b0)) u_sr (
        .CLK_DRV(clk), .RESET(rst), .CLK_IN(ck[0][0:0]), .PRE_N(pn[0][0:0]), .CLR_N(cn[0][0:0]),
        .A(av[0][0:0]), .B(bv[0][0:0]), .Q(q0), .Q_N(qn0));

    clocked_ff_bank #(.N(4), .MODE(MODE_JK), .EDGE(EDGE_FALL), .FILTER(0), .INIT(4'h0)) u_jk (
        .CLK_DRV(clk), .RESET(rst), .CLK_IN(ck[1][3:0]), .PRE_N(pn[1][3:0]), .CLR_N(cn[1][3:0]),
        .A(av[1][3:0]), .B(bv[1][3:0]), .Q(q1), .Q_N(qn1));

    clocked_ff_bank #(.N(2), .MODE(MODE_D), .EDGE(EDGE_RISE), .FILTER(3), .INIT(2'b00)) u_d (
        .CLK_DRV(clk), .RESET(rst), .CLK_IN(ck[2][1:0]), .PRE_N(pn[2][1:0]), .CLR_N(cn[2][1:0]),
        .A(av[2][1:0]), .B(bv[2][1:0]), .Q(q2), .Q_N(qn2));

    clocked_ff_bank #(.N(8), .MODE(MODE_T), .EDGE(EDGE_FALL), .FILTER(2), .INIT(8'hA5)) u_t (
        .CLK_DRV(clk), .RESET(rst), .CLK_IN(ck[3]), .PRE_N(pn[3]), .CLR_N(cn[3]),
        .A(av[3]), .B(bv[3]), .Q(q3), .Q_N(qn3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] q_obs(int i);
        case (i)
            0:       return 8'(q0);
            1:       return 8'(q1);
            2:       return 8'(q2);
            default: return q3;
        endcase
    endfunction

    function automatic logic [7:0] qn_obs(int i);
        case (i)
            0:       return 8'(qn0);
            1:       return 8'(qn1);
            2:       return 8'(qn2);
            default: return qn3;
        endcase
    endfunction

    // Truth tables of the four flip-flop personalities.
    function automatic bit ref_next(int md, bit a, bit b, bit q);
        case (md)
            0:       return (a && !b) ? 1'b1 : ((!a && b) ? 1'b0 : q);
            1:       return (a && b) ? !q : (a ? 1'b1 : (b ? 1'b0 : q));
            2:       return a;
            default: return a ? !q : q;
        endcase
    endfunction

    function automatic bit forced(int i, int k, int c);
        return !pn_h[i][k][c] || !cn_h[i][k][c];
    endfunction

    // Edge accepted at cycle tt: the line sat at the active level for the last
    // FE samples, nothing interrupted the run, and the cycle before the run
    // counted as inactive (real inactive level, reset, or preset/clear).
    function automatic bit accepted(int i, int tt, int c);
        int s;
        s = tt - FE[i];
        if (s < 0) return 1'b0;
        for (int k = s + 1; k <= tt; k++)
            if (ck_h[i][k][c] != ACTL[i]) return 1'b0;
        for (int k = s + 1; k < tt; k++)
            if (rst_h[k] || forced(i, k, c)) return 1'b0;
        return (ck_h[i][s][c] != ACTL[i]) || rst_h[s] || forced(i, s, c);
    endfunction

    // One CLK_DRV cycle: apply staged inputs, then model and compare mid-cycle.
    task automatic cyc();
        logic [7:0] e;
        logic [7:0] mask;
        bit qp, da, db;
        int s;
        @(posedge clk);
        #1;
        rst = st_rst;
        for (int i = 0; i < NINST; i++) begin
            ck[i] = st_ck[i];
            pn[i] = st_pn[i];
            cn[i] = st_cn[i];
            av[i] = st_av[i];
            bv[i] = st_bv[i];
        end
        @(negedge clk);
        rst_h[t] = rst;
        for (int i = 0; i < NINST; i++) begin
            ck_h[i][t] = ck[i];
            pn_h[i][t] = pn[i];
            cn_h[i][t] = cn[i];
            av_h[i][t] = av[i];
            bv_h[i][t] = bv[i];
        end
        for (int i = 0; i < NINST; i++) begin
            e    = '0;
            mask = 8'((1 << NB[i]) - 1);
            for (int c = 0; c < NB[i]; c++) begin
                qp = (t == 0) ? INITV[i][c] : exp_h[i][t-1][c];
                if (rst)
                    e[c] = INITV[i][c];
                else if (!pn[i][c])
                    e[c] = 1'b1;
                else if (!cn[i][c])
                    e[c] = 1'b0;
                else if (accepted(i, t, c)) begin
                    s  = t - FE[i];
                    da = rst_h[s] ? 1'b0 : av_h[i][s][c];
                    db = rst_h[s] ? 1'b0 : bv_h[i][s][c];
                    e[c] = ref_next(MD[i], da, db, qp);
                end else
                    e[c] = qp;
            end
            exp_h[i][t] = e;
            check($sformatf("q%0d", i), 32'(q_obs(i)), 32'(e));
            check($sformatf("qn%0d", i), 32'(qn_obs(i)), 32'(~e & mask));
        end
        t++;
    endtask

    initial begin
        rst    = 1'b1;
        st_rst = 1'b1;
        for (int i = 0; i < NINST; i++) begin
            ck[i] = 8'h00; pn[i] = 8'hFF; cn[i] = 8'hFF; av[i] = 8'h00; bv[i] = 8'h00;
            st_ck[i] = ACTL[i] ? 8'h00 : 8'hFF;
            st_pn[i] = 8'hFF;
            st_cn[i] = 8'hFF;
            st_av[i] = 8'h00;
            st_bv[i] = 8'h00;
        end

        // Reset: Q shows INIT.
        cyc();
        cyc();
        check("rst_init_t", 32'(q3), 32'hA5);
        check("rst_init_sr", 32'(q0), 32'h0);
        st_rst = 1'b0;
        cyc();

        // SR: set, illegal 11 holds, reset.
        st_av[0] = 8'h01; st_bv[0] = 8'h00;
        cyc(); cyc();
        st_ck[0] = 8'h00; cyc();
        check("sr_set", 32'(q0), 32'h1);
        st_ck[0] = 8'hFF; st_av[0] = 8'h01; st_bv[0] = 8'h01;
        cyc(); cyc();
        st_ck[0] = 8'h00; cyc();
        check("sr_hold11", 32'(q0), 32'h1);
        st_ck[0] = 8'hFF; st_av[0] = 8'h00; st_bv[0] = 8'h01;
        cyc(); cyc();
        st_ck[0] = 8'h00; cyc();
        check("sr_reset", 32'(q0), 32'h0);
        st_ck[0] = 8'hFF; cyc();

        // JK: toggle three times, then data changed only in the edge cycle.
        st_av[1] = 8'h0F; st_bv[1] = 8'h0F;
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            st_ck[1] = 8'h00; cyc();
            check("jk_toggle", 32'(q1), (k % 2 == 0) ? 32'hF : 32'h0);
            st_ck[1] = 8'hFF; cyc();
        end
        st_av[1] = 8'h00; st_bv[1] = 8'h00;
        cyc(); cyc();
        st_av[1] = 8'h0F; st_bv[1] = 8'h0F; st_ck[1] = 8'h00;
        cyc();
        check("jk_olddata", 32'(q1), 32'hF);
        st_ck[1] = 8'hFF; cyc();

        // D, rising edge, filter 3: glitch rejected, long pulse accepted.
        st_av[2] = 8'h03;
        cyc();
        st_ck[2] = 8'h03; cyc(); cyc();
        st_ck[2] = 8'h00; cyc();
        check("d_glitch", 32'(q2), 32'h0);
        st_ck[2] = 8'h03;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("d_filter", 32'(q2), (k >= 2) ? 32'h3 : 32'h0);
        end
        st_ck[2] = 8'h00; cyc();

        // Preset / clear on the D bank with the line inactive.
        st_cn[2] = 8'h00; cyc();
        check("clr_imm", 32'(q2), 32'h0);
        st_cn[2] = 8'hFF; cyc();
        check("clr_hold", 32'(q2), 32'h0);
        st_pn[2] = 8'h00; cyc();
        check("pre_imm", 32'(q2), 32'h3);
        st_pn[2] = 8'hFF; cyc(); cyc();
        check("pre_release", 32'(q2), 32'h3);
        st_pn[2] = 8'h00; st_cn[2] = 8'h00; cyc();
        check("pre_clr_both", 32'(q2), 32'h3);
        st_pn[2] = 8'hFF; st_cn[2] = 8'hFF; cyc();

        // T with INIT A5, filter 2: reset mid-filter, then one clean edge.
        st_av[3] = 8'hFF; cyc();
        st_ck[3] = 8'h00; cyc();
        check("t_first", 32'(q3), 32'hA5);
        st_rst = 1'b1; cyc();
        check("t_rst_mid", 32'(q3), 32'hA5);
        st_rst = 1'b0; st_ck[3] = 8'hFF; cyc();
        check("t_discard", 32'(q3), 32'hA5);
        cyc();
        st_ck[3] = 8'h00; cyc();
        check("t_edge0", 32'(q3), 32'hA5);
        cyc();
        check("t_toggle", 32'(q3), 32'h5A);
        st_ck[3] = 8'hFF; cyc();

        // Random traffic on all banks.
        for (int n = 0; n < 1500; n++) begin
            st_rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NINST; i++) begin
                st_ck[i] = st_ck[i] ^ (8'($urandom) & 8'($urandom));
                st_av[i] = 8'($urandom);
                st_bv[i] = 8'($urandom);
                st_pn[i] = ~(8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom));
                st_cn[i] = ~(8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom));
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
